// File: rtl/mux_nway_scan.sv
// Registered N-way channel multiplexer with a manual select mode and a
// one-shot ascending scan over a latched set of enabled channels. The output
// is a single valid/ready register stage.
module mux_nway_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS-1:0]       en_mask,
  input  logic                      start,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]          state_q, state_d;
  // Channels still to be emitted in the current scan; bits clear as beats load.
  logic [CHANNELS-1:0] mask_q, mask_d;
  // Set when the beat sitting in the output register is the final scan beat.
  logic                last_q, last_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                valid_q, valid_d;

  logic [WIDTH-1:0]    chan [CHANNELS];
  logic [WIDTH-1:0]    manual_data;
  logic [WIDTH-1:0]    scan_data;
  logic [SEL_W-1:0]    scan_sel;
  logic [CHANNELS-1:0] mask_rest;
  logic                load;
  logic                fire;

  // Split the flat input bus into per-channel words.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      chan[k] = in_bus[k*WIDTH +: WIDTH];
    end
  end

  // Manual select; an index beyond the last channel yields zero data.
  always_comb begin
    manual_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_in == SEL_W'(k)) manual_data = chan[k];
    end
  end

  // Lowest pending channel; descending loop so the lowest match wins.
  always_comb begin
    scan_data = '0;
    scan_sel  = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (mask_q[k]) begin
        scan_data = chan[k];
        scan_sel  = SEL_W'(k);
      end
    end
  end

  // Clearing the lowest set bit drops the channel about to be emitted.
  assign mask_rest = mask_q & (mask_q - CHANNELS'(1));
  assign load      = !valid_q || out_ready;
  assign fire      = valid_q && out_ready;

  // Next-state for the FSM, the scan bookkeeping and the output register.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    last_d  = last_q;
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    case (state_q)
      StIdle: begin
        if (!mode) begin
          if (load) begin
            data_d  = manual_data;
            sel_d   = sel_in;
            valid_d = 1'b1;
          end
        end else begin
          if (load) valid_d = 1'b0;
          if (start) begin
            mask_d  = en_mask;
            last_d  = 1'b0;
            state_d = (en_mask == '0) ? StDone : StScan;
          end
        end
      end
      StScan: begin
        if (load) begin
          if (mask_q != '0) begin
            data_d  = scan_data;
            sel_d   = scan_sel;
            valid_d = 1'b1;
            mask_d  = mask_rest;
            last_d  = (mask_rest == '0);
          end else begin
            valid_d = 1'b0;
          end
        end
        // Final beat leaving the register: nothing is left to load, so the
        // register is empty on entry to StDone.
        if (fire && last_q) begin
          last_d  = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (load) valid_d = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output register, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mask_q  <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == StScan);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_mux_nway_scan.sv
// Directed bench for mux_nway_scan: reset, manual-mode vector table, and
// hand-written scan sequences (full, sparse with back-pressure, empty, reset).
module tb_mux_nway_scan;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 8;
  localparam int SEL_W    = 3;

  logic                      clk;
  logic                      rst;
  logic [CHANNELS*WIDTH-1:0] in_bus;
  logic                      mode;
  logic [SEL_W-1:0]          sel_in;
  logic [CHANNELS-1:0]       en_mask;
  logic                      start;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;
  logic                      done;

  int checks = 0;
  int errors = 0;

  mux_nway_scan #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bus    (in_bus),
    .mode      (mode),
    .sel_in    (sel_in),
    .en_mask   (en_mask),
    .start     (start),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SEL_W-1:0]          sel;
    logic                      ready;
    logic [CHANNELS*WIDTH-1:0] bus;
    logic [WIDTH-1:0]          exp_data;
    logic [SEL_W-1:0]          exp_sel;
    logic                      exp_valid;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CHANNELS*WIDTH-1:0] bus_onehot();
    logic [CHANNELS*WIDTH-1:0] b;
    for (int k = 0; k < CHANNELS; k++) b[k*WIDTH +: WIDTH] = 8'(1 << k);
    return b;
  endfunction

  function automatic logic [CHANNELS*WIDTH-1:0] bus_count();
    logic [CHANNELS*WIDTH-1:0] b;
    for (int k = 0; k < CHANNELS; k++) b[k*WIDTH +: WIDTH] = 8'(k + 1);
    return b;
  endfunction

  initial begin
    logic [CHANNELS*WIDTH-1:0] oh;
    logic [CHANNELS*WIDTH-1:0] oh7f;
    logic                      v;
    logic [WIDTH-1:0]          d;
    logic [SEL_W-1:0]          s;
    logic                      rdy;
    logic                      done_seen;
    logic                      busy_seen;
    logic                      valid_seen;
    int                        nbeats;
    int                        ndone;
    logic [SEL_W-1:0]          beat_sel [8];
    logic [WIDTH-1:0]          beat_data [8];

    // Table: manual walk, channel 7 swap to 7F, a stall, then a reselect.
    oh   = bus_onehot();
    oh7f = oh;
    oh7f[7*WIDTH +: WIDTH] = 8'h7F;
    for (int k = 0; k < 8; k++) begin
      vecs[k] = '{sel: SEL_W'(k), ready: 1'b1, bus: oh, exp_data: 8'(1 << k),
                  exp_sel: SEL_W'(k), exp_valid: 1'b1};
    end
    vecs[8]  = '{sel: 3'd7, ready: 1'b1, bus: oh7f, exp_data: 8'h7F, exp_sel: 3'd7,
                 exp_valid: 1'b1};
    vecs[9]  = '{sel: 3'd2, ready: 1'b0, bus: oh7f, exp_data: 8'h7F, exp_sel: 3'd7,
                 exp_valid: 1'b1};
    vecs[10] = '{sel: 3'd2, ready: 1'b1, bus: oh7f, exp_data: 8'h04, exp_sel: 3'd2,
                 exp_valid: 1'b1};

    // Reset state, then first manual beat.
    rst       = 1'b1;
    mode      = 1'b0;
    sel_in    = 3'd3;
    in_bus    = '0;
    in_bus[3*WIDTH +: WIDTH] = 8'hA5;
    en_mask   = '0;
    start     = 1'b0;
    out_ready = 1'b0;
    #3;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("first_data", 32'(out_data), 32'hA5);
    check("first_sel", 32'(out_sel), 32'd3);
    check("first_valid", 32'(out_valid), 32'd1);

    // Asynchronous reset mid-cycle with a stalled beat in the register.
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", 32'(out_data), 32'd0);
    check("async_rst_sel", 32'(out_sel), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_data", 32'(out_data), 32'hA5);
    check("post_rst_sel", 32'(out_sel), 32'd3);
    check("post_rst_valid", 32'(out_valid), 32'd1);

    // Manual-mode vector table.
    for (int i = 0; i < 11; i++) begin
      sel_in    = vecs[i].sel;
      out_ready = vecs[i].ready;
      in_bus    = vecs[i].bus;
      tick();
      check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_sel", i), 32'(out_sel), 32'(vecs[i].exp_sel));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
    end

    // Full scan, ready held high.
    in_bus    = bus_count();
    out_ready = 1'b1;
    mode      = 1'b1;
    tick();
    check("scan_idle_valid", 32'(out_valid), 32'd0);
    en_mask = 8'hFF;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("full_busy_start", 32'(busy), 32'd1);
    check("full_valid_start", 32'(out_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("full_beat%0d_sel", k), 32'(out_sel), 32'(k));
      check($sformatf("full_beat%0d_data", k), 32'(out_data), 32'(k + 1));
      check($sformatf("full_beat%0d_vb", k), {30'd0, out_valid, busy}, 32'd3);
      check($sformatf("full_beat%0d_done", k), 32'(done), 32'd0);
    end
    tick();
    check("full_done_pulse", 32'(done), 32'd1);
    check("full_done_busy_valid", {30'd0, busy, out_valid}, 32'd0);
    tick();
    check("full_done_end", 32'(done), 32'd0);

    // Sparse scan with toggling ready, mask change and stray start mid-scan.
    en_mask = 8'b1010_0100;
    start   = 1'b1;
    tick();
    start     = 1'b0;
    nbeats    = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      rdy       = c[0];
      out_ready = rdy;
      if (c == 3) en_mask = 8'hFF;
      start = (c == 2);
      v = out_valid;
      d = out_data;
      s = out_sel;
      tick();
      if (v && rdy) begin
        if (nbeats < 8) begin
          beat_sel[nbeats]  = s;
          beat_data[nbeats] = d;
        end
        nbeats++;
      end
      if (v && !rdy) begin
        check($sformatf("stall_hold_c%0d", c), {23'd0, out_valid, out_sel, out_data},
              {23'd0, 1'b1, s, d});
      end
      if (done) done_seen = 1'b1;
    end
    start = 1'b0;
    check("sparse_done_seen", 32'(done_seen), 32'd1);
    check("sparse_beat_count", 32'(nbeats), 32'd3);
    if (nbeats >= 3) begin
      check("sparse_order", {23'd0, beat_sel[0], beat_sel[1], beat_sel[2]},
            {23'd0, 3'd2, 3'd5, 3'd7});
      check("sparse_data", {8'd0, beat_data[0], beat_data[1], beat_data[2]},
            {8'd0, 8'd3, 8'd6, 8'd8});
    end
    check("sparse_busy_after", 32'(busy), 32'd0);
    out_ready = 1'b1;
    tick();

    // Empty mask: one done pulse, no beats, never busy.
    en_mask    = '0;
    start      = 1'b1;
    ndone      = 0;
    busy_seen  = 1'b0;
    valid_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      start = 1'b0;
      if (done) ndone++;
      if (busy) busy_seen = 1'b1;
      if (out_valid) valid_seen = 1'b1;
    end
    check("empty_done_count", 32'(ndone), 32'd1);
    check("empty_busy_seen", 32'(busy_seen), 32'd0);
    check("empty_valid_seen", 32'(valid_seen), 32'd0);

    // Reset in the middle of a scan.
    en_mask = 8'hFF;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("midscan_busy_before", {30'd0, busy, out_valid}, 32'd3);
    #3;
    rst = 1'b1;
    #1;
    check("midscan_rst_busy_valid", {30'd0, busy, out_valid}, 32'd0);
    check("midscan_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done || busy || out_valid) ndone++;
    end
    check("midscan_no_resume", 32'(ndone), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
